// File: rtl/dsp_phase_est_pkg.sv
// Shared types and constants for the phase/frequency estimator: FSM encoding,
// CORDIC arctangent table and its scaling helper.
package dsp_phase_est_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ATAN_ENTRIES = 24;

    // Fractional bits carried below the sample LSB so late iterations still move y.
    localparam int CORDIC_GUARD = 8;

    // round(atan(2^-k) / (2*pi) * 2^32)
    localparam logic [31:0] ATAN [ATAN_ENTRIES] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
    };

    // Rescale a table entry to a narrower phase word, rounding to nearest.
    function automatic logic [31:0] atan_scaled(input int k, input int phi_width);
        logic [32:0] v;
        int          sh;
        sh = 32 - phi_width;
        v  = {1'b0, ATAN[k]};
        if (sh > 0) begin
            v = (v + (33'd1 << (sh - 1))) >> sh;
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/dsp_cordic_vec.sv
// Iterative vectoring CORDIC: quadrant pre-rotation on load, one micro-rotation
// per run cycle, zero-input override and a done strobe on the final iteration.
module dsp_cordic_vec
    import dsp_phase_est_pkg::*;
#(
    parameter int PHI_WIDTH  = 32,
    parameter int DATA_WIDTH = 12,
    parameter int ITERS      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    output logic                  last,
    output logic                  done,
    output logic [PHI_WIDTH-1:0]  res_phase,
    output logic [DATA_WIDTH+1:0] res_mag
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int W  = XW + CORDIC_GUARD;
    localparam int KW = $clog2(ITERS);

    logic [PHI_WIDTH-1:0] atan_tab [ITERS];

    genvar gi;
    generate
        for (gi = 0; gi < ITERS; gi++) begin : g_atan
            assign atan_tab[gi] = PHI_WIDTH'(atan_scaled(gi, PHI_WIDTH));
        end
    endgenerate

    logic signed [W-1:0]  i_ext, q_ext;
    logic signed [W-1:0]  x_reg, y_reg, x_next, y_next, x_sh, y_sh;
    logic [PHI_WIDTH-1:0] z_reg, z_next;
    logic [KW-1:0]        k_reg;
    logic                 zero_reg;

    assign i_ext = {{(XW - DATA_WIDTH){i_in[DATA_WIDTH-1]}}, i_in, {CORDIC_GUARD{1'b0}}};
    assign q_ext = {{(XW - DATA_WIDTH){q_in[DATA_WIDTH-1]}}, q_in, {CORDIC_GUARD{1'b0}}};

    always_comb begin
        x_sh = x_reg >>> k_reg;
        y_sh = y_reg >>> k_reg;
        if (!y_reg[W-1]) begin
            x_next = x_reg + y_sh;
            y_next = y_reg - x_sh;
            z_next = z_reg + atan_tab[k_reg];
        end else begin
            x_next = x_reg - y_sh;
            y_next = y_reg + x_sh;
            z_next = z_reg - atan_tab[k_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg    <= '0;
            zero_reg <= 1'b0;
        end else if (load) begin
            // Left half-plane: rotate by pi so the core only sees |angle| <= pi/2.
            if (i_in[DATA_WIDTH-1]) begin
                x_reg <= -i_ext;
                y_reg <= -q_ext;
                z_reg <= {1'b1, {(PHI_WIDTH - 1){1'b0}}};
            end else begin
                x_reg <= i_ext;
                y_reg <= q_ext;
                z_reg <= '0;
            end
            k_reg    <= '0;
            zero_reg <= (i_in == '0) && (q_in == '0);
        end else if (run) begin
            x_reg <= x_next;
            y_reg <= y_next;
            z_reg <= z_next;
            k_reg <= k_reg + KW'(1);
        end
    end

    assign last      = (k_reg == KW'(ITERS - 1));
    assign done      = run && last;
    assign res_phase = zero_reg ? '0 : z_next;
    assign res_mag   = zero_reg ? '0 : x_next[W-1:CORDIC_GUARD];

endmodule

// File: rtl/dsp_phase_est.sv
// Phase/frequency estimator top: handshake FSM, result registers and the
// phase-difference averager that produces the frequency word.
module dsp_phase_est
    import dsp_phase_est_pkg::*;
#(
    parameter int PHI_WIDTH  = 32,
    parameter int DATA_WIDTH = 12,
    parameter int ITERS      = 16,
    parameter int AVG_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    output logic                  out_valid,
    output logic [PHI_WIDTH-1:0]  phase_o,
    output logic [DATA_WIDTH+1:0] mag_o,
    output logic                  freq_valid,
    output logic [PHI_WIDTH-1:0]  freq_o
);

    localparam int AW = PHI_WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    state_t state_reg, state_next;
    logic   clear, accept, run, last, done;

    logic [PHI_WIDTH-1:0]  res_phase;
    logic [DATA_WIDTH+1:0] res_mag;

    assign clear    = rst || !en;
    assign in_ready = (state_reg == ST_IDLE) && !clear;
    assign accept   = in_valid && in_ready;
    assign run      = (state_reg == ST_ROT) && !clear;

    dsp_cordic_vec #(
        .PHI_WIDTH (PHI_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ITERS     (ITERS)
    ) u_cordic (
        .clk      (clk),
        .rst      (clear),
        .load     (accept),
        .run      (run),
        .i_in     (i_in),
        .q_in     (q_in),
        .last     (last),
        .done     (done),
        .res_phase(res_phase),
        .res_mag  (res_mag)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_ROT;
            ST_ROT:  if (last)   state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    logic                  out_valid_reg, freq_valid_reg, prev_valid_reg;
    logic [PHI_WIDTH-1:0]  phase_reg, freq_reg, prev_reg, diff, freq_next;
    logic [DATA_WIDTH+1:0] mag_reg;
    logic signed [AW-1:0]  acc_reg, acc_sum;
    logic [CW-1:0]         cnt_reg, cnt_inc;
    logic                  window_full;

    // The modular phase difference read as signed is the wrap-free step.
    always_comb begin
        diff        = res_phase - prev_reg;
        acc_sum     = acc_reg + AW'($signed(diff));
        freq_next   = PHI_WIDTH'(acc_sum >>> AVG_LOG2);
        cnt_inc     = cnt_reg + CW'(1);
        window_full = (cnt_inc == CW'(2 ** AVG_LOG2));
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            out_valid_reg  <= 1'b0;
            freq_valid_reg <= 1'b0;
            phase_reg      <= '0;
            mag_reg        <= '0;
            freq_reg       <= '0;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
        end else begin
            out_valid_reg  <= done;
            freq_valid_reg <= 1'b0;
            if (done) begin
                phase_reg <= res_phase;
                mag_reg   <= res_mag;
                prev_reg  <= res_phase;
                if (!prev_valid_reg) begin
                    prev_valid_reg <= 1'b1;
                end else if (window_full) begin
                    freq_reg       <= freq_next;
                    freq_valid_reg <= 1'b1;
                    acc_reg        <= '0;
                    cnt_reg        <= '0;
                end else begin
                    acc_reg <= acc_sum;
                    cnt_reg <= cnt_inc;
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign phase_o    = phase_reg;
    assign mag_o      = mag_reg;
    assign freq_valid = freq_valid_reg;
    assign freq_o     = freq_reg;

endmodule

// File: tb/tb_dsp_phase_est.sv
// Scoreboard bench for dsp_phase_est: expected phase/magnitude/frequency come
// from a floating-point reference and are matched against each output pulse.
module tb_dsp_phase_est;

    localparam int  PW = 32;
    localparam int  DW = 12;
    localparam real PI = 3.14159265358979323846;
    localparam int  PTOL = 131072;

    logic          clk = 1'b0;
    logic          rst, en, in_valid;
    logic [DW-1:0] i_in, q_in;
    logic          in_ready, out_valid, freq_valid;
    logic [PW-1:0] phase_o, freq_o;
    logic [DW+1:0] mag_o;

    dsp_phase_est dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .out_valid (out_valid),
        .phase_o   (phase_o),
        .mag_o     (mag_o),
        .freq_valid(freq_valid),
        .freq_o    (freq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] phase;
        int          mag;
        int          ptol;
        int          mtol;
        longint      acc_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] freq;
        int          tol;
    } fexp_t;

    exp_t   sb[$];
    fexp_t  fq[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     freq_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_phase(input int iv, input int qv);
        real    a;
        longint p;
        a = $atan2(real'(qv), real'(iv));
        if (a < 0.0) a = a + 2.0 * PI;
        p = longint'(a / (2.0 * PI) * 4294967296.0);
        return p[31:0];
    endfunction

    function automatic int ref_mag(input int iv, input int qv);
        real g, s;
        g = 1.0;
        s = 1.0;
        for (int k = 0; k < 16; k++) begin
            g = g * $sqrt(1.0 + s);
            s = s / 4.0;
        end
        return int'($sqrt(real'(iv * iv + qv * qv)) * g);
    endfunction

    // Output monitor: pops the scoreboard on every result and frequency pulse.
    always @(negedge clk) begin : mon
        exp_t        e;
        fexp_t       f;
        logic [31:0] d;
        int          sd, md;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_valid at cycle %0d phase=%h mag=%0d, required no output", cyc, phase_o, mag_o);
            end else begin
                e = sb.pop_front();
                d = phase_o - e.phase;
                sd = $signed(d);
                if (sd < 0) sd = -sd;
                checks++;
                if (sd > e.ptol) begin
                    errors++;
                    $display("FAIL phase got=%h required=%h +/-%0d", phase_o, e.phase, e.ptol);
                end
                md = int'(mag_o) - e.mag;
                if (md < 0) md = -md;
                checks++;
                if (md > e.mtol) begin
                    errors++;
                    $display("FAIL mag got=%0d required=%0d +/-%0d", mag_o, e.mag, e.mtol);
                end
                checks++;
                if (cyc - e.acc_cyc != 17) begin
                    errors++;
                    $display("FAIL latency got=%0d required=17", cyc - e.acc_cyc);
                end
                $display("result phase=%h mag=%0d (exp %h / %0d) latency=%0d", phase_o, mag_o, e.phase, e.mag, cyc - e.acc_cyc);
            end
        end
        if (freq_valid) begin
            freq_seen++;
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_freq_valid freq=%h, required no pulse", freq_o);
            end else begin
                f = fq.pop_front();
                d = freq_o - f.freq;
                sd = $signed(d);
                if (sd < 0) sd = -sd;
                checks++;
                if (sd > f.tol) begin
                    errors++;
                    $display("FAIL freq got=%h required=%h +/-%0d", freq_o, f.freq, f.tol);
                end
                $display("freq freq_o=%h (exp %h)", freq_o, f.freq);
            end
        end
    end

    task automatic send(input int iv, input int qv, input int ptol, input int mtol, input bit expect_out);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        i_in     = DW'(iv);
        q_in     = DW'(qv);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            e.phase   = ref_phase(iv, qv);
            e.mag     = ref_mag(iv, qv);
            e.ptol    = ptol;
            e.mtol    = mtol;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || fq.size() != 0) && w < 600) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() != 0 || fq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending results=%0d freqs=%0d required 0", sb.size(), fq.size());
            sb.delete();
            fq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Ideal rotation of amplitude 2000, phase advancing by step per sample.
    task automatic drive_rot(input logic [31:0] start, input logic [31:0] step, input int n);
        logic [31:0] ph;
        real         a;
        ph = start;
        for (int k = 0; k < n; k++) begin
            a = real'(longint'(ph)) / 4294967296.0 * 2.0 * PI;
            send(int'(2000.0 * $cos(a)), int'(2000.0 * $sin(a)), PTOL, 3, 1'b1);
            ph = ph + step;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; i_in = DW'(100); q_in = DW'(50);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready got=%b required=0", in_ready);
            end
            checks++;
            if ({out_valid, freq_valid, phase_o, mag_o, freq_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got ov=%b fv=%b ph=%h mag=%0d fr=%h required all 0", out_valid, freq_valid, phase_o, mag_o, freq_o);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got=%b required=1", in_ready);
        end
        $display("reset check done in_ready=%b", in_ready);
    endtask

    task automatic test_axis();
        send(2047, 0, PTOL, 3, 1'b1);
        send(0, 2047, PTOL, 3, 1'b1);
        send(-2047, 0, PTOL, 3, 1'b1);
        send(0, -2047, PTOL, 3, 1'b1);
        drain();
    endtask

    task automatic test_corners();
        send(-2048, -2048, PTOL, 4, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        send(1500, -700, PTOL, 3, 1'b1);
        send(-300, 1900, PTOL, 3, 1'b1);
        drain();
    endtask

    task automatic test_freq(input logic [31:0] start, input logic [31:0] step, input int windows);
        fexp_t f;
        pulse_rst();
        f.freq = step;
        f.tol  = PTOL;
        for (int w = 0; w < windows; w++) fq.push_back(f);
        drive_rot(start, step, 1 + 16 * windows);
        drain();
    endtask

    task automatic test_handshake();
        longint acc[$];
        @(negedge clk);
        in_valid = 1'b1;
        i_in = DW'(1500);
        q_in = DW'(-700);
        for (int c = 0; c < 100; c++) begin
            if (in_ready) begin
                exp_t e;
                e.phase   = ref_phase(1500, -700);
                e.mag     = ref_mag(1500, -700);
                e.ptol    = PTOL;
                e.mtol    = 3;
                e.acc_cyc = cyc;
                sb.push_back(e);
                if (acc.size() != 0) begin
                    checks++;
                    if (cyc - acc[$] != 18) begin
                        errors++;
                        $display("FAIL accept_interval got=%0d required=18", cyc - acc[$]);
                    end
                end
                acc.push_back(cyc);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 6) begin
            errors++;
            $display("FAIL accept_count got=%0d required=6", acc.size());
        end
        $display("handshake acceptances=%0d", acc.size());
        drain();
    endtask

    // Drop en or pulse rst part-way through; the next window needs 17 fresh samples.
    task automatic test_restart(input bit use_rst);
        fexp_t f;
        int    seen;
        pulse_rst();
        drive_rot(32'h1000_0000, 32'h0800_0000, 8);
        drain();
        if (use_rst) begin
            pulse_rst();
        end else begin
            send(1000, 1000, 0, 0, 1'b0);
            repeat (4) @(negedge clk);
            en = 1'b0;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b0 || {phase_o, mag_o, freq_o} !== '0) begin
                    errors++;
                    $display("FAIL en_low_clear got rdy=%b ph=%h mag=%0d fr=%h required all 0", in_ready, phase_o, mag_o, freq_o);
                end
            end
            en = 1'b1;
            repeat (25) @(negedge clk);
        end
        seen = freq_seen;
        drive_rot(32'h3000_0000, 32'h0800_0000, 16);
        drain();
        checks++;
        if (freq_seen != seen) begin
            errors++;
            $display("FAIL early_freq_valid got=%0d pulses required=0", freq_seen - seen);
        end
        f.freq = 32'h0800_0000;
        f.tol  = PTOL;
        fq.push_back(f);
        drive_rot(32'h3000_0000 + 32'h8000_0000, 32'h0800_0000, 1);
        drain();
        $display("restart (%s) window check done", use_rst ? "rst" : "en");
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; i_in = '0; q_in = '0;
        test_reset();
        test_axis();
        test_corners();
        test_freq(32'h1100_0000, 32'h0800_0000, 1);
        test_freq(32'h0200_0000, 32'hF800_0000, 2);
        test_handshake();
        test_restart(1'b0);
        test_restart(1'b1);
        checks++;
        if (sb.size() != 0 || fq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations results=%0d freqs=%0d required 0", sb.size(), fq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog_timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
